// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO fed by core stores, STATUS readback.
// Frames are sent LSB first with CLKS_PER_BIT clocks per bit.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        tx,
    output logic        busy
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned BW = 16;
    localparam logic [31:0]   STATUS_ADDR = BASE_ADDR + 32'd4;
    localparam logic [BW-1:0] BIT_RELOAD  = BW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          empty, full;
    logic          data_hit, push, pop, ovf_set, ovf_clr;

    logic [1:0]    state, state_nx;
    logic [BW-1:0] bit_cnt, bit_cnt_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic [7:0]    shift, shift_nx;
    logic          tx_nx;
    logic [4:0]    count_ext;

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign data_hit = MemWrite && (DataAdr == BASE_ADDR);
    // A pop at the same edge frees the slot, so a push into a full FIFO is still accepted
    assign push     = data_hit && (!full || pop);
    assign ovf_set  = data_hit && full && !pop;
    assign ovf_clr  = MemWrite && (DataAdr == STATUS_ADDR) && WriteData[3];

    assign busy      = (state != IDLE) || !empty;
    assign count_ext = 5'(count);
    assign ReadData  = (DataAdr == STATUS_ADDR)
                     ? {24'b0, count_ext[3:0], overflow, busy, empty, full}
                     : 32'b0;

    // Next-state and bit timing
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        tx_nx      = tx;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                tx_nx = 1'b1;
                if (!empty) begin
                    pop        = 1'b1;
                    shift_nx   = mem[rd_ptr];
                    state_nx   = START;
                    tx_nx      = 1'b0;
                    bit_cnt_nx = BIT_RELOAD;
                end
            end
            START: begin
                if (bit_cnt == '0) begin
                    state_nx   = DATA;
                    bit_idx_nx = 3'd0;
                    tx_nx      = shift[0];
                    bit_cnt_nx = BIT_RELOAD;
                end else begin
                    bit_cnt_nx = bit_cnt - BW'(1);
                end
            end
            DATA: begin
                if (bit_cnt == '0) begin
                    bit_cnt_nx = BIT_RELOAD;
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                        tx_nx    = 1'b1;
                    end else begin
                        bit_idx_nx = bit_idx + 3'd1;
                        tx_nx      = shift[1];
                        shift_nx   = {1'b0, shift[7:1]};
                    end
                end else begin
                    bit_cnt_nx = bit_cnt - BW'(1);
                end
            end
            STOP: begin
                if (bit_cnt == '0) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_nx   = mem[rd_ptr];
                        state_nx   = START;
                        tx_nx      = 1'b0;
                        bit_cnt_nx = BIT_RELOAD;
                    end else begin
                        state_nx   = IDLE;
                        tx_nx      = 1'b1;
                        bit_cnt_nx = '0;
                    end
                end else begin
                    bit_cnt_nx = bit_cnt - BW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                tx_nx    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            bit_idx <= bit_idx_nx;
            shift   <= shift_nx;
            tx      <= tx_nx;
        end
    end

    // FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
            if (ovf_clr)      overflow <= 1'b0;
            else if (ovf_set) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) mem[wr_ptr] <= WriteData[7:0];
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: a frame-level model checked every cycle against tx, busy and
// ReadData, plus directed scenarios with hand-computed literal expectations.
module tb_mmio_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam logic [31:0] STAT  = 32'h0000_0104;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        tx;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    mmio_uart_tx #(
        .BASE_ADDR(BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .MemWrite(MemWrite),
        .DataAdr(DataAdr),
        .WriteData(WriteData),
        .ReadData(ReadData),
        .tx(tx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Frame-level model: queue of pending bytes and the frame currently on the line
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    bit         m_active = 1'b0;
    int         m_pos = 0;
    logic [9:0] m_frame = 10'h3FF;
    int         m_sz;
    bit         m_popped;

    always @(posedge clk) begin
        if (reset) begin
            q.delete();
            m_ovf    = 1'b0;
            m_active = 1'b0;
            m_pos    = 0;
        end else begin
            m_sz     = q.size();
            m_popped = 1'b0;
            if (m_active) begin
                m_pos++;
                if (m_pos == 10 * CPB) m_active = 1'b0;
            end
            if (!m_active && m_sz > 0) begin
                m_frame  = {1'b1, q.pop_front(), 1'b0};
                m_active = 1'b1;
                m_pos    = 0;
                m_popped = 1'b1;
            end
            if (MemWrite && DataAdr == BASE) begin
                if (m_sz < DEPTH || m_popped) q.push_back(WriteData[7:0]);
                else m_ovf = 1'b1;
            end
            if (MemWrite && DataAdr == STAT && WriteData[3]) m_ovf = 1'b0;
        end
    end

    function automatic logic m_tx();
        return m_active ? m_frame[m_pos / CPB] : 1'b1;
    endfunction

    function automatic logic m_busy();
        return m_active || (q.size() > 0);
    endfunction

    function automatic logic [31:0] m_status();
        logic [3:0] c;
        c = 4'(q.size());
        return {24'b0, c, m_ovf, m_busy(), q.size() == 0, q.size() == DEPTH};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, sampled 1 time unit after the active edge
    always @(posedge clk) begin
        #1;
        check("model_tx", 32'(tx), 32'(m_tx()));
        check("model_busy", 32'(busy), 32'(m_busy()));
        check("model_readdata", ReadData, (DataAdr == STAT) ? m_status() : 32'h0);
    end

    task automatic idle_bus();
        MemWrite  = 1'b0;
        DataAdr   = STAT;
        WriteData = 32'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        MemWrite  = 1'b1;
        DataAdr   = a;
        WriteData = d;
        @(negedge clk);
        idle_bus();
    endtask

    task automatic cyc(input int n);
        idle_bus();
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_idle(input int max);
        int k;
        k = 0;
        while (busy && k < max) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", 32'(busy), 32'h0);
    endtask

    logic [9:0] pat;

    initial begin
        reset = 1'b1;
        idle_bus();
        repeat (2) @(negedge clk);
        #1;
        check("reset_tx", 32'(tx), 32'h1);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_status", ReadData, 32'h0000_0002);

        // Single frame of 0x55, pushed at the first edge out of reset
        reset = 1'b0;
        wr(BASE, 32'hFFFF_FF55);
        pat = {1'b1, 8'h55, 1'b0};
        for (int j = 1; j <= 41; j++) begin
            @(negedge clk);
            if (j % 4 == 2 && j <= 40) check("frame55_bit", 32'(tx), 32'(pat[(j - 2) / 4]));
            if (j == 40) check("frame55_busy_last", 32'(busy), 32'h1);
            if (j == 41) check("frame55_busy_end", 32'(busy), 32'h0);
        end
        cyc(3);

        // Three back-to-back bytes
        wr(BASE, 32'h41);
        wr(BASE, 32'h42);
        wr(BASE, 32'h43);
        #1;
        check("b2b_status", ReadData, 32'h0000_0024);
        wait_idle(200);
        cyc(3);

        // Overflow: one in flight, four queued, fifth dropped
        wr(BASE, 32'h11);
        for (int i = 0; i < 5; i++) wr(BASE, 32'hA1 + 32'(i));
        #1;
        check("ovf_status", ReadData, 32'h0000_004D);
        wr(STAT, 32'h8);
        #1;
        check("ovf_clear", ReadData, 32'h0000_0045);
        wait_idle(300);
        #1;
        check("ovf_drain", ReadData, 32'h0000_0002);
        cyc(3);

        // Writes that must not start a frame
        wr(STAT, 32'h0);
        wr(32'h108, 32'hFF);
        cyc(5);
        #1;
        check("nop_tx", 32'(tx), 32'h1);
        check("nop_status", ReadData, 32'h0000_0002);
        DataAdr = 32'h108;
        #1;
        check("other_addr_read", ReadData, 32'h0);
        cyc(2);

        // Reset in the middle of data bit 3, with a concurrent store
        wr(BASE, 32'h3C);
        cyc(17);
        check("mid_frame_busy", 32'(busy), 32'h1);
        reset     = 1'b1;
        MemWrite  = 1'b1;
        DataAdr   = BASE;
        WriteData = 32'h99;
        @(negedge clk);
        reset = 1'b0;
        idle_bus();
        #1;
        check("rst_tx", 32'(tx), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_status", ReadData, 32'h0000_0002);
        cyc(50);

        // Full FIFO with a push landing on the STOP-end pop
        wr(BASE, 32'h01);
        for (int i = 0; i < 4; i++) wr(BASE, 32'hB1 + 32'(i));
        cyc(36);
        wr(BASE, 32'hC5);
        #1;
        check("full_pushpop_status", ReadData, 32'h0000_0045);
        wait_idle(400);
        cyc(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
